// File: rtl/dp_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dp_seq_pkg
// Description : Shared types and constants for the datapath command
//               sequencer: opcode enum, ALU select codes, FSM state enum
//               and the datapath data width.
// Revision    : 1.0 - initial release
// ============================================================================
package dp_seq_pkg;

    localparam int DATA_W = 4;

    typedef enum logic [2:0] {
        OP_LOAD = 3'b000,
        OP_AND  = 3'b001,
        OP_OR   = 3'b010,
        OP_XOR  = 3'b011,
        OP_ADD  = 3'b100,
        OP_READ = 3'b101,
        OP_ILL6 = 3'b110,
        OP_ILL7 = 3'b111
    } op_e;

    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_XOR = 2'b10;
    localparam logic [1:0] ALU_ADD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Opcodes that drive the datapath (LOAD and the four ALU ops).
    function automatic logic op_is_exec(input op_e op);
        return (op <= OP_ADD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dp_seq_rpt_cnt.sv
`default_nettype none
// ============================================================================
// Module      : dp_seq_rpt_cnt
// Description : Loadable down-counter that tracks the remaining EXEC cycles
//               of a command and flags the final one.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               i_load         - load i_load_val (command accept)
//               i_load_val     - number of EXEC cycles (>= 1)
//               i_dec          - one EXEC cycle consumed
//               o_last         - current EXEC cycle is the last one
// Revision    : 1.0 - initial release
// ============================================================================
module dp_seq_rpt_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_last
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && !o_last) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // A count of 0 only exists out of reset; treating it as "last" keeps a
    // stray EXEC entry from ever running 2^CNT_W cycles.
    assign o_last = (r_cnt <= CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/dp_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dp_sequencer
// Description : Command sequencer for the 4-bit mux/register/ALU datapath.
//               Accepts opcodes on a valid/ready command channel, drives the
//               datapath for one or more EXEC cycles and returns register
//               value, accumulated ADD carry and error on a valid/ready
//               response channel.
// Config      : DP_SEQ_REPEAT_EN - when defined, ADD runs max(cmd_cnt,1)
//               cycles via dp_seq_rpt_cnt; otherwise every op runs one
//               cycle and cmd_cnt is ignored.
// Ports       : clk, rst                  - clock, sync active-high reset
//               cmd_valid/ready/op/data/cnt - command channel
//               rsp_valid/ready/data/carry/err - response channel
//               dp_*                      - datapath control and status
// Revision    : 1.0 - initial release
// ============================================================================
module dp_sequencer
    import dp_seq_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [CNT_W-1:0]  cmd_cnt,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_carry,
    output logic              rsp_err,
    output logic [DATA_W-1:0] dp_mux_in_data,
    output logic [DATA_W-1:0] dp_alu_in_data,
    output logic              dp_mux_sel,
    output logic              dp_load,
    output logic [1:0]        dp_alu_sel,
    input  logic [DATA_W-1:0] dp_reg_out,
    input  logic              dp_carry_out
);

    state_e            r_state;
    state_e            w_state_nxt;
    op_e               r_op;
    logic [DATA_W-1:0] r_data;
    logic              r_carry;
    logic              r_err;
    op_e               w_cmd_op;
    logic              w_accept;
    logic              w_last;

    assign w_cmd_op = op_e'(cmd_op);
    assign w_accept = cmd_valid && cmd_ready;

`ifdef DP_SEQ_REPEAT_EN
    logic [CNT_W-1:0] w_cnt_init;

    // Only ADD repeats; a zero count still executes once.
    assign w_cnt_init = (w_cmd_op == OP_ADD && cmd_cnt != '0) ? cmd_cnt : CNT_W'(1);

    dp_seq_rpt_cnt #(
        .CNT_W      (CNT_W)
    ) u_rpt_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_load_val (w_cnt_init),
        .i_dec      (r_state == ST_EXEC),
        .o_last     (w_last)
    );
`else
    logic w_unused_cnt;

    assign w_unused_cnt = ^cmd_cnt;
    assign w_last       = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op    <= OP_LOAD;
            r_data  <= '0;
            r_carry <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op    <= w_cmd_op;
                r_data  <= cmd_data;
                r_carry <= 1'b0;
                r_err   <= (w_cmd_op == OP_ILL6) || (w_cmd_op == OP_ILL7);
            end else if (r_state == ST_EXEC && r_op == OP_ADD) begin
                r_carry <= r_carry | dp_carry_out;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        cmd_ready      = 1'b0;
        rsp_valid      = 1'b0;
        rsp_data       = '0;
        dp_mux_in_data = '0;
        dp_alu_in_data = '0;
        dp_mux_sel     = 1'b0;
        dp_load        = 1'b0;
        dp_alu_sel     = ALU_AND;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = !rst;
                if (cmd_valid && !rst) begin
                    w_state_nxt = op_is_exec(w_cmd_op) ? ST_EXEC : ST_RESP;
                end
            end
            ST_EXEC: begin
                dp_load = 1'b1;
                if (r_op == OP_LOAD) begin
                    dp_mux_in_data = r_data;
                end else begin
                    dp_mux_sel     = 1'b1;
                    dp_alu_in_data = r_data;
                    case (r_op)
                        OP_OR:   dp_alu_sel = ALU_OR;
                        OP_XOR:  dp_alu_sel = ALU_XOR;
                        OP_ADD:  dp_alu_sel = ALU_ADD;
                        default: dp_alu_sel = ALU_AND;
                    endcase
                end
                if (w_last) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                // The datapath register is not loaded in RESP, so this value
                // is held steady for as long as the consumer stalls.
                rsp_data  = dp_reg_out;
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign rsp_carry = r_carry;
    assign rsp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dp_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dp_sequencer
// Description : Self-checking bench for dp_sequencer with a behavioural
//               model of the 4-bit mux/register/ALU datapath.
//               Expectations follow DP_SEQ_REPEAT_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dp_sequencer;
    import dp_seq_pkg::*;

    localparam int CNT_W = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_data;
    logic [3:0] cmd_cnt;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic       rsp_carry;
    logic       rsp_err;
    logic [3:0] dp_mux_in_data;
    logic [3:0] dp_alu_in_data;
    logic       dp_mux_sel;
    logic       dp_load;
    logic [1:0] dp_alu_sel;
    logic [3:0] dp_reg_out;
    logic       dp_carry_out;

    always #5 clk = ~clk;

    dp_sequencer #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_data       (cmd_data),
        .cmd_cnt        (cmd_cnt),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_carry      (rsp_carry),
        .rsp_err        (rsp_err),
        .dp_mux_in_data (dp_mux_in_data),
        .dp_alu_in_data (dp_alu_in_data),
        .dp_mux_sel     (dp_mux_sel),
        .dp_load        (dp_load),
        .dp_alu_sel     (dp_alu_sel),
        .dp_reg_out     (dp_reg_out),
        .dp_carry_out   (dp_carry_out)
    );

    // Datapath model: register with no reset, mux, 4-bit ALU with carry.
    logic [3:0] dp_reg;
    logic [4:0] alu_res;

    always_comb begin
        alu_res = 5'd0;
        case (dp_alu_sel)
            2'b00: alu_res = {1'b0, dp_reg & dp_alu_in_data};
            2'b01: alu_res = {1'b0, dp_reg | dp_alu_in_data};
            2'b10: alu_res = {1'b0, dp_reg ^ dp_alu_in_data};
            default: alu_res = {1'b0, dp_reg} + {1'b0, dp_alu_in_data};
        endcase
    end

    assign dp_carry_out = alu_res[4];
    assign dp_reg_out   = dp_reg;

    always @(posedge clk) begin
        if (dp_load) dp_reg <= dp_mux_sel ? alu_res[3:0] : dp_mux_in_data;
    end

    typedef struct {
        logic [2:0] op;
        logic [3:0] data;
        logic [3:0] cnt;
        logic [3:0] exp_data;
        logic       exp_carry;
        logic       exp_err;
        int         exp_n;      // EXEC cycles; 0 for READ / illegal
    } vec_t;

    typedef struct packed {
        logic [3:0] data;
        logic       carry;
        logic       err;
    } exp_t;

    vec_t vecs[15];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [3:0] data, input logic [3:0] cnt,
                                input logic [3:0] ed, input logic ec, input logic ee, input int en);
        vec_t v;
        v.op = op; v.data = data; v.cnt = cnt;
        v.exp_data = ed; v.exp_carry = ec; v.exp_err = ee; v.exp_n = en;
        return v;
    endfunction

    function automatic logic [1:0] exp_alu(input logic [2:0] op);
        case (op)
            3'd2:    return 2'b01;
            3'd3:    return 2'b10;
            3'd4:    return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // Issues one command, tracks latency and datapath drive, then
    // completes the response handshake against the scoreboard.
    task automatic run_cmd(input vec_t v);
        int   waitc;
        int   lat;
        int   loads;
        exp_t e;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = v.op; cmd_data = v.data; cmd_cnt = v.cnt;
        waitc = 0;
        while (!cmd_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
        if (!cmd_ready) begin
            cmd_valid = 1'b0;
            return;
        end
        sb.push_back('{data: v.exp_data, carry: v.exp_carry, err: v.exp_err});
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat   = 0;
        loads = 0;
        do begin
            @(negedge clk);
            lat++;
            if (dp_load) begin
                loads++;
                if (loads == 1) begin
                    check("dp_mux_sel", {31'd0, dp_mux_sel}, {31'd0, (v.op != 3'd0)});
                    if (v.op == 3'd0) check("dp_mux_in_data", {28'd0, dp_mux_in_data}, {28'd0, v.data});
                    else begin
                        check("dp_alu_sel", {30'd0, dp_alu_sel}, {30'd0, exp_alu(v.op)});
                        check("dp_alu_in_data", {28'd0, dp_alu_in_data}, {28'd0, v.data});
                    end
                end
            end
        end while (!rsp_valid && lat < 40);
        check("rsp_latency", lat, v.exp_n + 1);
        check("load_cycles", loads, v.exp_n);
        rsp_ready = 1'b1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("rsp_data", {28'd0, rsp_data}, {28'd0, e.data});
            check("rsp_carry", {31'd0, rsp_carry}, {31'd0, e.carry});
            check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        end
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("rsp_valid_dropped", {31'd0, rsp_valid}, 32'd0);
        check("cmd_ready_after_rsp", {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  waitc;
        logic saw;

        vecs[0]  = mk(3'd0, 4'h9, 4'd0, 4'h9, 1'b0, 1'b0, 1);  // LOAD 9
        vecs[1]  = mk(3'd4, 4'h8, 4'd0, 4'h1, 1'b1, 1'b0, 1);  // ADD 8 -> 1, carry
        vecs[2]  = mk(3'd0, 4'h3, 4'd0, 4'h3, 1'b0, 1'b0, 1);  // LOAD 3
`ifdef DP_SEQ_REPEAT_EN
        vecs[3]  = mk(3'd4, 4'h5, 4'd3, 4'h2, 1'b1, 1'b0, 3);  // 8, D, 2+carry
`else
        vecs[3]  = mk(3'd4, 4'h5, 4'd3, 4'h8, 1'b0, 1'b0, 1);
`endif
        vecs[4]  = mk(3'd0, 4'hA, 4'd0, 4'hA, 1'b0, 1'b0, 1);  // LOAD A
        vecs[5]  = mk(3'd3, 4'hF, 4'd0, 4'h5, 1'b0, 1'b0, 1);  // XOR F
        vecs[6]  = mk(3'd1, 4'h6, 4'd0, 4'h4, 1'b0, 1'b0, 1);  // AND 6
        vecs[7]  = mk(3'd2, 4'h8, 4'd0, 4'hC, 1'b0, 1'b0, 1);  // OR 8
        vecs[8]  = mk(3'd5, 4'h0, 4'd0, 4'hC, 1'b0, 1'b0, 0);  // READ
        vecs[9]  = mk(3'd6, 4'h1, 4'd0, 4'hC, 1'b0, 1'b1, 0);  // illegal 110
        vecs[10] = mk(3'd7, 4'h2, 4'd5, 4'hC, 1'b0, 1'b1, 0);  // illegal 111
        vecs[11] = mk(3'd4, 4'h4, 4'd0, 4'h0, 1'b1, 1'b0, 1);  // ADD 4, cnt 0 -> once
`ifdef DP_SEQ_REPEAT_EN
        vecs[12] = mk(3'd4, 4'h1, 4'd2, 4'h2, 1'b0, 1'b0, 2);  // 1, 2
        vecs[13] = mk(3'd4, 4'hF, 4'd2, 4'h0, 1'b1, 1'b0, 2);  // 1c, 0c
        vecs[14] = mk(3'd4, 4'h1, 4'd3, 4'h3, 1'b0, 1'b0, 3);  // carry cleared
`else
        vecs[12] = mk(3'd4, 4'h1, 4'd2, 4'h1, 1'b0, 1'b0, 1);
        vecs[13] = mk(3'd4, 4'hF, 4'd2, 4'h0, 1'b1, 1'b0, 1);
        vecs[14] = mk(3'd4, 4'h1, 4'd3, 4'h1, 1'b0, 1'b0, 1);
`endif

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 4'h0; cmd_cnt = 4'd0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        cmd_valid = 1'b1;
        #1;
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_carry", {31'd0, rsp_carry}, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_dp_load", {31'd0, dp_load}, 32'd0);
        check("rst_dp_ctrl", {25'd0, dp_mux_sel, dp_alu_sel, dp_mux_in_data}, 32'd0);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1 check("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        for (int i = 0; i < 15; i++) run_cmd(vecs[i]);

        // Backpressure: LOAD 7, stall response while pulsing cmd_valid.
        run_cmd(mk(3'd0, 4'h7, 4'd0, 4'h7, 1'b0, 1'b0, 1));
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_data = 4'h7;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        waitc = 0;
        while (!rsp_valid && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        check("bp_rsp_valid_seen", {31'd0, rsp_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            cmd_valid = (i % 2 == 0); cmd_op = 3'd0; cmd_data = 4'h2;
            @(negedge clk);
            check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_rsp_data", {28'd0, rsp_data}, 32'h7);
            check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            check("bp_dp_load", {31'd0, dp_load}, 32'd0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        saw = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) saw = 1'b1;
        end
        check("bp_no_extra_rsp", {31'd0, saw}, 32'd0);
        run_cmd(mk(3'd5, 4'h0, 4'd0, 4'h7, 1'b0, 1'b0, 0));  // LOAD 2 was dropped

        // Reset two cycles after an ADD accept: no response, ready right after.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd4; cmd_data = 4'h1; cmd_cnt = 4'd8;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
                check("post_rst_dp_load", {31'd0, dp_load}, 32'd0);
                check("post_rst_carry", {31'd0, rsp_carry}, 32'd0);
            end
            if (rsp_valid) saw = 1'b1;
        end
        check("post_rst_no_rsp", {31'd0, saw}, 32'd0);
        run_cmd(mk(3'd0, 4'h5, 4'd0, 4'h5, 1'b0, 1'b0, 1));
        run_cmd(mk(3'd5, 4'h0, 4'd0, 4'h5, 1'b0, 1'b0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dp_sequencer.md
# dp_sequencer

Command sequencer for the 4-bit mux/register/ALU datapath. Accepts opcodes over a valid/ready command channel and drives the datapath's mux select, register load, ALU select and operand inputs for one or more cycles. Returns the resulting register value and carry over a valid/ready response channel. Sits between a host/test controller and the datapath inside the datapath top level.

## Interface
- CNT_W, 4: width of the repeat count.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  opcode: 000 LOAD, 001 AND, 010 OR, 011 XOR, 100 ADD, 101 READ, 110/111 illegal.
- cmd_data  in  4  immediate for LOAD, or ALU operand b.
- cmd_cnt  in  CNT_W  repeat count for ADD (0 treated as 1).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  4  datapath register value after the command.
- rsp_carry  out  1  OR of the ALU carry over all ADD cycles of the command.
- rsp_err  out  1  illegal opcode.
- dp_mux_in_data  out  4  datapath mux input a.
- dp_alu_in_data  out  4  datapath ALU operand b.
- dp_mux_sel  out  1  0 = external data, 1 = ALU result.
- dp_load  out  1  register load enable.
- dp_alu_sel  out  2  00 AND, 01 OR, 10 XOR, 11 ADD.
- dp_reg_out  in  4  datapath register value.
- dp_carry_out  in  1  datapath ALU carry.

## Operation
- FSM states and transitions:
  - IDLE: cmd_ready=1. On handshake, latch op/data/count. Go to EXEC for LOAD/AND/OR/XOR/ADD; go to RESP for READ or an illegal opcode.
  - EXEC: dp_load=1 every cycle. Down-counter loaded with max(cmd_cnt,1) for ADD and 1 for all other ops. Leave to RESP when the count reaches 1.
  - RESP: rsp_valid=1. rsp_data = dp_reg_out. Hold all response outputs until rsp_ready=1, then go to IDLE.
- EXEC drive per opcode:
  - LOAD: dp_mux_sel=0, dp_mux_in_data=cmd_data.
  - ALU ops: dp_mux_sel=1, dp_alu_in_data=cmd_data, dp_alu_sel = op−1.
- Outside EXEC, all dp_* outputs are 0.
- Carry:
  - The carry flag clears on command accept.
  - In EXEC with op ADD, the flag ORs in dp_carry_out every cycle. It stays 0 for other ops.
- rsp_err=1 only for opcodes 110/111. The datapath register is not loaded for these.
- The datapath register has no reset. READ before any LOAD returns an undefined value; benches must LOAD first.
- Reset values: state IDLE, cmd_ready=0 while rst=1, rsp_valid=0, rsp_carry=0, rsp_err=0, all dp_* =0, counter 0.
- Reset mid-operation: EXEC/RESP abort immediately and no response is issued. The register keeps whatever partial value was loaded.
- cmd_valid outside IDLE is ignored, with no queuing. cmd_ready is low in EXEC and RESP.

## Timing
- Accept at edge T. EXEC occupies cycles T+1 … T+N. rsp_valid rises at T+N+1.
- For N=1, the response appears two cycles after accept.
- READ/illegal: rsp_valid at T+1.
- After the response handshake at edge R, cmd_ready=1 from R+1.
- Minimum command period is 3 cycles (READ: 2).
- rsp_* outputs are registered and stable while rsp_valid=1 && rsp_ready=0.

## Configuration
- DP_SEQ_REPEAT_EN defined: ADD repeats max(cmd_cnt,1) times using the down-counter.
- DP_SEQ_REPEAT_EN undefined:
  - cmd_cnt is ignored, but the port remains.
  - Every operation has N=1.
  - The counter logic is removed.

## Structure
- Shared package dp_seq_pkg holds:
  - the opcode enum;
  - ALU select constants (AND/OR/XOR/ADD);
  - the FSM state enum (IDLE, EXEC, RESP);
  - the data width constant, 4.
- One natural sub-module: dp_seq_rpt_cnt, the loadable down-counter with last-cycle flag. It is instantiated only under DP_SEQ_REPEAT_EN.

## Test plan
- Reset, then LOAD 4'h9 → EXEC one cycle with dp_load=1, dp_mux_sel=0; rsp_valid at T+2; rsp_data=9, rsp_carry=0, rsp_err=0.
- LOAD 9, then ADD 8 → dp_alu_sel=11, dp_mux_sel=1; rsp_data=1, rsp_carry=1.
- LOAD 3, then ADD 5 with cnt=3 (REPEAT_EN) → three EXEC cycles (8, 13, 2+carry); rsp at T+4; rsp_data=2, rsp_carry=1. Without the macro: rsp_data=8, carry 0.
- LOAD A, then XOR F → 5; AND 4'h6 → 4; OR 4'h8 → C; each with rsp_carry=0.
- Backpressure: hold rsp_ready=0 for 5 cycles while pulsing cmd_valid → rsp_* stable, cmd_ready=0, no extra command accepted.
- Opcode 110 → rsp_err=1 at T+1, dp_load never asserted. ADD cnt=8 with rst pulsed after 2 EXEC cycles → no rsp_valid; cmd_ready=1 the cycle after rst deasserts.
